bit_serial_addsub_ctrl: RTL and testbench
=========================================

Name: bit_serial_addsub_ctrl

Overview:
Sequencer for a single 1-bit full-adder slice (SUM = A^B^CIN, COUT = majority). It performs a WIDTH-bit add or subtract bit-serially, LSB first, one bit per clock. It sits beside the ALU as an area-minimal add/sub unit driven by the CPU control unit with a START/DONE handshake. It also reports carry, overflow and zero flags.

Parameters:
WIDTH, 16, operand/result width in bits; legal range is 2 or more.
CNT_W, $clog2(WIDTH+1), width of the internal bit counter; derived, do not override.

Ports:
CLK  input  1  system clock; all state changes on the rising edge.
RST_N  input  1  asynchronous, active-low reset.
START  input  1  request; sampled only in IDLE.
SUB  input  1  0 = A+B, 1 = A-B; sampled with START.
A  input  WIDTH  operand A; sampled with START.
B  input  WIDTH  operand B; sampled with START.
BUSY  output  1  high while the operation is in RUN.
DONE  output  1  one-cycle pulse; RESULT and flags are valid.
RESULT  output  WIDTH  sum/difference; held until the next accepted START.
COUT  output  1  final carry out; for SUB, 1 = no borrow.
OVF  output  1  signed overflow = carry into MSB XOR carry out of MSB.
ZERO  output  1  RESULT == 0.

Behaviour:
- Clock and reset: one clock domain (CLK); reset is asynchronous and active-low (RST_N).
- Reset values: state = IDLE; BUSY, DONE, RESULT, COUT, OVF, ZERO, shift registers, carry register and counter all 0.
- States: IDLE, RUN, FIN.
- IDLE:
  - START=1 at an edge: latch A into sa, latch B^{WIDTH{SUB}} into sb, set carry = SUB, cnt = 0, go to RUN.
  - BUSY rises after that edge.
- RUN, each edge:
  - The slice computes s, c from sa[0], sb[0], carry.
  - Shift s into the accumulator MSB (acc = {s, acc[WIDTH-1:1]}).
  - sa and sb shift right; carry = c; cnt++.
  - On the edge where cnt == WIDTH-2, capture the slice carry-out into c_msb_in; this is the carry into the MSB.
  - On the edge where cnt == WIDTH-1 (the last bit):
    - go to FIN;
    - RESULT = final acc;
    - COUT = c;
    - OVF = c_msb_in ^ c;
    - ZERO = (final acc == 0).
- FIN: DONE=1, BUSY=0; the next edge unconditionally goes to IDLE.
- Latency: START accepted at edge E0 → RUN edges E1..E_WIDTH → DONE high from E_WIDTH to E_WIDTH+1. For WIDTH=16, DONE is high for the 17th cycle after E0.
- START handling: ignored in RUN and FIN; no queuing. A, B and SUB changing during RUN have no effect.
- Outputs: RESULT and flags are updated only at the end of RUN; they hold their values through IDLE. They do not change on START.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no DONE is issued.
- Arithmetic: modulo 2^WIDTH; SUB is two's complement (A + ~B + 1).

Optional Feature:
Macro: BIT_SERIAL_ADDSUB_ABORT_EN.
- Defined:
  - Adds input ABORT (1 bit).
  - ABORT=1 at an edge in RUN forces IDLE, BUSY=0, and no DONE pulse; RESULT and flags keep their previous values.
  - ABORT has priority over completion on the last-bit edge.
  - ABORT is ignored in IDLE and FIN.
- Undefined: no ABORT port; every accepted START completes.

Test Plan:
- 0x1234 + 0x4321, SUB=0 → RESULT 0x5555, COUT 0, OVF 0, ZERO 0. BUSY high for 16 cycles; DONE is a single pulse 17 cycles after the START edge.
- 0xFFFF + 0x0001 → RESULT 0x0000, COUT 1, OVF 0, ZERO 1.
- 0x7FFF + 0x0001 → RESULT 0x8000, OVF 1, COUT 0. Also 0x8000 + 0x8000 → RESULT 0x0000, OVF 1, COUT 1.
- SUB: 0x0005 − 0x0007 → RESULT 0xFFFE, COUT 0. Also 0x0007 − 0x0005 → RESULT 0x0002, COUT 1.
- START re-asserted with new operands during RUN and during FIN → ignored; result equals the first operation. Next, RST_N pulsed low at RUN cycle 8 → all outputs 0 immediately, state IDLE, no DONE; a fresh START then completes normally.
- With BIT_SERIAL_ADDSUB_ABORT_EN: ABORT at RUN cycle 5 → no DONE pulse, BUSY low next cycle, RESULT still holds the previous 0x5555. ABORT on the final RUN edge → likewise no DONE.

Source files
------------

// File: rtl/bit_serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit add/subtract sequencer around one full-adder slice, LSB first.
// Optional ABORT input enabled by defining BIT_SERIAL_ADDSUB_ABORT_EN.
//
// state  | meaning
// S_IDLE | waiting for START; RESULT and flags hold
// S_RUN  | one operand bit per clock through the slice
// S_FIN  | DONE pulse, RESULT and flags valid
module bit_serial_addsub_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
`ifdef BIT_SERIAL_ADDSUB_ABORT_EN
  input  logic             ABORT,
`endif
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             COUT,
  output logic             OVF,
  output logic             ZERO
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               c_msb_in_q, c_msb_in_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  logic               slice_s;
  logic               slice_c;
  logic [WIDTH-1:0]   acc_shift;

  always_comb begin
    slice_s   = sa_q[0] ^ sb_q[0] ^ carry_q;
    slice_c   = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);
    acc_shift = {slice_s, acc_q[WIDTH-1:1]};

    state_d    = state_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    c_msb_in_d = c_msb_in_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          // subtraction is A + ~B + 1: invert B and seed the carry with SUB
          sa_d    = A;
          sb_d    = B ^ {WIDTH{SUB}};
          carry_d = SUB;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = acc_shift;
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        carry_d = slice_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 2)) begin
          c_msb_in_d = slice_c;
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = S_FIN;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = acc_shift;
          cout_d   = slice_c;
          ovf_d    = c_msb_in_q ^ slice_c;
          zero_d   = (acc_shift == '0);
        end
`ifdef BIT_SERIAL_ADDSUB_ABORT_EN
        // abort wins over completion, published results stay untouched
        if (ABORT) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b0;
          result_d = result_q;
          cout_d   = cout_q;
          ovf_d    = ovf_q;
          zero_d   = zero_q;
        end
`endif
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      sa_q       <= '0;
      sb_q       <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      c_msb_in_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      c_msb_in_q <= c_msb_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;
  assign COUT   = cout_q;
  assign OVF    = ovf_q;
  assign ZERO   = zero_q;

endmodule

// File: tb/tb_bit_serial_addsub_ctrl.sv
// Directed bench for bit_serial_addsub_ctrl (WIDTH=16); abort cases only when
// BIT_SERIAL_ADDSUB_ABORT_EN is defined.
module tb_bit_serial_addsub_ctrl;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic        ABORT;
  logic        SUB;
  logic [15:0] A;
  logic [15:0] B;
  logic        BUSY;
  logic        DONE;
  logic [15:0] RESULT;
  logic        COUT;
  logic        OVF;
  logic        ZERO;

  int n_vec  = 0;
  int n_miss = 0;

  // last published result/flags the DUT should still be holding
  logic [15:0] exp_r = 16'h0;
  logic        exp_c = 1'b0;
  logic        exp_o = 1'b0;
  logic        exp_z = 1'b0;

  bit_serial_addsub_ctrl #(.WIDTH(16)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .START  (START),
`ifdef BIT_SERIAL_ADDSUB_ABORT_EN
    .ABORT  (ABORT),
`endif
    .SUB    (SUB),
    .A      (A),
    .B      (B),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .RESULT (RESULT),
    .COUT   (COUT),
    .OVF    (OVF),
    .ZERO   (ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with the DUT idle.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic [15:0] er, input logic ec,
                        input logic eo, input logic ez, input bit poke);
    int busy_n, done_n, done_k;
    logic [15:0] got_r;
    logic got_c, got_o, got_z;
    busy_n = 0; done_n = 0; done_k = -1;
    got_r = 16'hxxxx; got_c = 1'bx; got_o = 1'bx; got_z = 1'bx;
    START = 1'b1; A = a; B = b; SUB = sub;
    @(posedge CLK); #1;
    START = 1'b0;
    chk({tag, "/hold_on_start"}, 32'(RESULT), 32'(exp_r));
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) begin
        @(posedge CLK); #1;
      end
      if (BUSY) busy_n++;
      if (DONE) begin
        done_n++;
        if (done_k < 0) begin
          done_k = k;
          got_r = RESULT; got_c = COUT; got_o = OVF; got_z = ZERO;
        end
      end
      if (poke && k == 3) begin
        START = 1'b1; A = ~a; B = 16'h0F0F; SUB = ~sub;
      end
      if (poke && k == 4) START = 1'b0;
      if (poke && k == 16) START = 1'b1;
      if (poke && k == 17) START = 1'b0;
    end
    chk({tag, "/busy_cycles"}, 32'(busy_n), 32'd16);
    chk({tag, "/done_pulses"}, 32'(done_n), 32'd1);
    chk({tag, "/done_edge"},   32'(done_k), 32'd16);
    chk({tag, "/result"}, 32'(got_r), 32'(er));
    chk({tag, "/cout"},   32'(got_c), 32'(ec));
    chk({tag, "/ovf"},    32'(got_o), 32'(eo));
    chk({tag, "/zero"},   32'(got_z), 32'(ez));
    chk({tag, "/result_held"}, 32'(RESULT), 32'(er));
    exp_r = er; exp_c = ec; exp_o = eo; exp_z = ez;
  endtask

`ifdef BIT_SERIAL_ADDSUB_ABORT_EN
  task automatic run_abort(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input int abort_k);
    int done_n;
    done_n = 0;
    START = 1'b1; A = a; B = b; SUB = 1'b0;
    @(posedge CLK); #1;
    START = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) begin
        @(posedge CLK); #1;
      end
      if (DONE) done_n++;
      if (k == abort_k + 1) begin
        chk({tag, "/busy_after_abort"}, 32'(BUSY), 32'd0);
        ABORT = 1'b0;
      end
      if (k == abort_k) ABORT = 1'b1;
    end
    chk({tag, "/done_pulses"}, 32'(done_n), 32'd0);
    chk({tag, "/result_kept"}, 32'(RESULT), 32'(exp_r));
    chk({tag, "/flags_kept"}, 32'({COUT, OVF, ZERO}), 32'({exp_c, exp_o, exp_z}));
  endtask
`endif

  initial begin
    int bad_done, bad_busy;
    RST_N = 1'b0; START = 1'b0; ABORT = 1'b0; SUB = 1'b0; A = 16'h0; B = 16'h0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset/busy",   32'(BUSY),   32'd0);
    chk("reset/done",   32'(DONE),   32'd0);
    chk("reset/result", 32'(RESULT), 32'd0);
    chk("reset/flags",  32'({COUT, OVF, ZERO}), 32'd0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    run_op("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("add_8000_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
    run_op("sub_0005_0007", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sub_0007_0005", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("sub_0000_0000", 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("sub_8000_0001", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("ignore_start",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1);

    // reset in the middle of RUN
    START = 1'b1; A = 16'hFFFF; B = 16'h0001; SUB = 1'b0;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (8) @(posedge CLK);
    #1;
    chk("midreset/busy_before", 32'(BUSY), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("midreset/busy",   32'(BUSY),   32'd0);
    chk("midreset/done",   32'(DONE),   32'd0);
    chk("midreset/result", 32'(RESULT), 32'd0);
    chk("midreset/flags",  32'({COUT, OVF, ZERO}), 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    bad_done = 0; bad_busy = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLK); #1;
      if (DONE) bad_done++;
      if (BUSY) bad_busy++;
    end
    chk("midreset/no_done", 32'(bad_done), 32'd0);
    chk("midreset/idle",    32'(bad_busy), 32'd0);
    exp_r = 16'h0; exp_c = 1'b0; exp_o = 1'b0; exp_z = 1'b0;
    run_op("after_reset", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef BIT_SERIAL_ADDSUB_ABORT_EN
    run_abort("abort_k5",   16'hFFFF, 16'h0001, 5);
    run_abort("abort_last", 16'hFFFF, 16'h0001, 15);
    run_op("after_abort", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
